// File: rtl/memory_pkg.sv
// Shared word-width defaults and FSM state encoding for the serializer and
// the memoryunit that consumes its data/sl stream.
package memory_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int SL_W_DEF  = $clog2(WIDTH_DEF);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
endpackage

// File: rtl/sl_counter.sv
// Bit-index counter: clears on accept, advances when enabled, wraps after LAST.
module sl_counter
  import memory_pkg::*;
#(
  parameter int SL_W = SL_W_DEF,
  parameter int LAST = WIDTH_DEF - 1
) (
  input  logic            reclk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  output logic [SL_W-1:0] sl,
  output logic            wrap
);

  logic [SL_W-1:0] sl_reg;

  // wrap flags the advancing edge that leaves the last bit position
  assign wrap = en && (sl_reg == SL_W'(LAST));
  assign sl   = sl_reg;

  always_ff @(posedge reclk or negedge rst) begin
    if (!rst) begin
      sl_reg <= '0;
    end else if (clr) begin
      sl_reg <= '0;
    end else if (en) begin
      sl_reg <= wrap ? '0 : sl_reg + 1'b1;
    end
  end

endmodule

// File: rtl/memory_reader.sv
// Parallel-to-serial reader: latches a word on accept and presents it LSB first,
// selecting bits by index rather than shifting, with stall and end-of-frame pulse.
module memory_reader
  import memory_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SL_W  = SL_W_DEF
) (
  input  logic             reclk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             hold,
  output logic             ready,
  output logic             data,
  output logic [SL_W-1:0]  sl,
  output logic             valid,
  output logic             done
);

  state_t           state_reg;
  state_t           state_next;
  logic [WIDTH-1:0] shreg_reg;
  logic             accept;
  logic             advance;
  logic             wrap;
  logic             in_shift;

  assign in_shift = (state_reg == ST_SHIFT);
  assign ready    = !in_shift;
  assign accept   = load && ready;
  assign advance  = in_shift && !hold;

  sl_counter #(
    .SL_W (SL_W),
    .LAST (WIDTH - 1)
  ) u_sl_counter (
    .reclk (reclk),
    .rst   (rst),
    .clr   (accept),
    .en    (advance),
    .sl    (sl),
    .wrap  (wrap)
  );

  always_ff @(posedge reclk or negedge rst) begin
    if (!rst) begin
      state_reg <= ST_IDLE;
      shreg_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        shreg_reg <= din;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (accept) state_next = ST_SHIFT;
      ST_SHIFT: if (wrap) state_next = ST_DONE;
      ST_DONE:  state_next = accept ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // the word is never shifted; sl alone picks the live bit
  assign data  = in_shift ? shreg_reg[sl] : 1'b0;
  assign valid = advance;
  assign done  = (state_reg == ST_DONE);

endmodule

// File: tb/tb_memory_reader.sv
// Directed and randomized frames checked against a per-cycle behavioural model
// of the serial stream, including a bit-by-index loopback receiver.
module tb_memory_reader;
  localparam int WIDTH = 16;
  localparam int SL_W  = 4;

  logic             reclk = 1'b0;
  logic             rst   = 1'b0;
  logic             load  = 1'b0;
  logic [WIDTH-1:0] din   = '0;
  logic             hold  = 1'b0;
  logic             ready;
  logic             data;
  logic [SL_W-1:0]  sl;
  logic             valid;
  logic             done;

  int checks = 0;
  int errors = 0;

  memory_reader #(.WIDTH(WIDTH), .SL_W(SL_W)) dut (
    .reclk (reclk),
    .rst   (rst),
    .load  (load),
    .din   (din),
    .hold  (hold),
    .ready (ready),
    .data  (data),
    .sl    (sl),
    .valid (valid),
    .done  (done)
  );

  always #5 reclk = ~reclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_data"},  32'(data),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_done"},  32'(done),  32'd0);
    chk({tag, "_ready"}, 32'(ready), 32'd1);
    chk({tag, "_sl"},    32'(sl),    32'd0);
  endtask

  // Called at posedge+1; block is idle after the previous edge.
  task automatic idle_cycle(input string tag);
    load = 1'b0;
    hold = 1'($urandom_range(0, 1));
    din  = 16'($urandom);
    @(negedge reclk);
    chk_quiet(tag);
    @(posedge reclk); #1;
  endtask

  // One frame. Called at posedge+1. preloaded: the accept edge already happened.
  // hmode: 0 no stall, 1 stall in cycles 4..6, 2 random stalls.
  // abort_pos >= 0 pulls rst low while that bit is on the line.
  task automatic run_frame(input string tag, input logic [WIDTH-1:0] word,
                           input bit preloaded, input int hmode, input bit busy,
                           input int abort_pos, input bit chain,
                           input logic [WIDTH-1:0] next_word);
    int cyc;
    int pos;
    int holds;
    bit h;
    logic [WIDTH-1:0] rx;
    if (!preloaded) begin
      load = 1'b1;
      din  = word;
      hold = 1'($urandom_range(0, 1));
      @(negedge reclk);
      chk({tag, "_ready_at_load"}, 32'(ready), 32'd1);
      @(posedge reclk); #1;
    end
    cyc = 1; pos = 0; holds = 0; rx = '0;
    while (pos < WIDTH) begin
      if (cyc > 200) begin
        chk({tag, "_timeout"}, 32'(cyc), 32'd0);
        return;
      end
      case (hmode)
        1:       h = (cyc >= 4) && (cyc <= 6);
        2:       h = ($urandom_range(0, 3) == 0);
        default: h = 1'b0;
      endcase
      hold = h;
      if (busy && pos == 5) begin
        load = 1'b1; din = 16'hFFFF;
      end else begin
        load = 1'($urandom_range(0, 1)); din = 16'($urandom);
      end
      @(negedge reclk);
      chk({tag, "_sl"},    32'(sl),    32'(pos));
      chk({tag, "_data"},  32'(data),  32'((word >> pos) & 1));
      chk({tag, "_valid"}, 32'(valid), 32'(!h));
      chk({tag, "_ready"}, 32'(ready), 32'd0);
      chk({tag, "_done"},  32'(done),  32'd0);
      if (valid) rx[sl] = data;
      if (abort_pos == pos) begin
        #2 rst = 1'b0;
        #1 chk_quiet({tag, "_async_rst"});
        load = 1'b0;
        @(posedge reclk); #1;
        load = 1'b1;
        din  = 16'($urandom);
        @(negedge reclk);
        chk_quiet({tag, "_in_rst"});
        @(posedge reclk); #1;
        rst  = 1'b1;
        load = 1'b0;
        return;
      end
      @(posedge reclk); #1;
      if (!h) pos++;
      else holds++;
      cyc++;
    end
    load = chain;
    din  = next_word;
    hold = 1'($urandom_range(0, 1));
    @(negedge reclk);
    chk({tag, "_done"},      32'(done),  32'd1);
    chk({tag, "_done_ready"}, 32'(ready), 32'd1);
    chk({tag, "_done_valid"}, 32'(valid), 32'd0);
    chk({tag, "_done_data"},  32'(data),  32'd0);
    chk({tag, "_done_cycle"}, 32'(cyc),   32'(WIDTH + 1 + holds));
    chk({tag, "_rx_word"},    32'(rx),    32'(word));
    if (hmode == 1) chk({tag, "_stall_done_cycle"}, 32'(cyc), 32'd20);
    @(posedge reclk); #1;
    load = 1'b0;
    $display("frame %s word=%04h holds=%0d done_cycle=%0d rx=%04h", tag, word, holds, cyc, rx);
  endtask

  initial begin
    bit chain;
    bit pre;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] nw;
    rst = 1'b0;
    #3;
    chk_quiet("reset");
    @(posedge reclk); #1;
    rst = 1'b1;
    idle_cycle("idle0");

    run_frame("word",  16'hA5C3, 1'b0, 0, 1'b0, -1, 1'b0, 16'h0);
    idle_cycle("idle1");
    run_frame("stall", 16'h00F0, 1'b0, 1, 1'b0, -1, 1'b0, 16'h0);
    idle_cycle("idle2");
    run_frame("busy",  16'h0000, 1'b0, 0, 1'b1, -1, 1'b0, 16'h0);
    idle_cycle("idle3");
    run_frame("b2b_a", 16'hFFFF, 1'b0, 0, 1'b0, -1, 1'b1, 16'h0001);
    run_frame("b2b_b", 16'h0001, 1'b1, 0, 1'b0, -1, 1'b0, 16'h0);
    idle_cycle("idle4");
    run_frame("abort", 16'h5A5A, 1'b0, 0, 1'b0, 7, 1'b0, 16'h0);
    $display("frame abort word=5a5a reset at sl=7");
    run_frame("after_rst", 16'h1234, 1'b0, 0, 1'b0, -1, 1'b0, 16'h0);
    idle_cycle("idle5");
    run_frame("loopback", 16'hBEEF, 1'b0, 0, 1'b0, -1, 1'b0, 16'h0);

    pre = 1'b0;
    w = 16'($urandom);
    for (int i = 0; i < 8; i++) begin
      chain = 1'($urandom_range(0, 1));
      nw = 16'($urandom);
      run_frame("rand", w, pre, 2, 1'b0, -1, chain, nw);
      pre = chain;
      w = chain ? nw : 16'($urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
